// File: rtl/adc_stream_fifo.sv
// Packs pairs of 16-bit ADC samples into 32-bit words and queues them in a show-ahead FIFO.
// Optional overflow counter is built only when ADC_STREAM_FIFO_OVF_COUNT_EN is defined.
module adc_stream_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] EMPTY_DATA = 32'hDEADBEEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_sample_valid,
    input  logic [15:0]           i_sample,
    output logic [31:0]           o_rx_data,
    input  logic                  i_rx_data_read_trigger,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [15:0]           o_overflow_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    // Handshakes: a sample is taken on every edge where i_sample_valid is high (no
    // backpressure); a pop happens on every edge where the trigger is high and the
    // FIFO is not empty. i_clear wins over both.
    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } packer_state_t;

    packer_state_t         packer_state, packer_state_next;
    logic [15:0]           pending;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  push_req, push_ok, pop, drop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) packer_state <= ST_LOW;
        else       packer_state <= packer_state_next;
    end

    always_comb begin
        packer_state_next = packer_state;
        push_req          = 1'b0;
        if (i_sample_valid) begin
            if (packer_state == ST_LOW) begin
                packer_state_next = ST_HIGH;
            end else begin
                packer_state_next = ST_LOW;
                push_req          = 1'b1;
            end
        end
        if (i_clear) begin
            packer_state_next = ST_LOW;
            push_req          = 1'b0;
        end
    end

    // Popping frees the slot on the same edge, so a full FIFO still accepts a push then.
    assign pop     = i_rx_data_read_trigger && !o_empty && !i_clear;
    assign push_ok = push_req && (!o_full || pop);
    assign drop    = push_req && !push_ok;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending <= 16'h0000;
        end else if (i_clear) begin
            pending <= 16'h0000;
        end else if (i_sample_valid && packer_state == ST_LOW) begin
            pending <= i_sample;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= {i_sample, pending};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else if (i_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   o_level <= o_level + LEVEL_ONE;
                2'b01:   o_level <= o_level - LEVEL_ONE;
                default: o_level <= o_level;
            endcase
        end
    end

    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == FULL_LEVEL);
    assign o_rx_data = o_empty ? EMPTY_DATA : mem[rd_ptr];

`ifdef ADC_STREAM_FIFO_OVF_COUNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow_count <= 16'h0000;
        end else if (i_clear) begin
            o_overflow_count <= 16'h0000;
        end else if (drop && o_overflow_count != 16'hFFFF) begin
            o_overflow_count <= o_overflow_count + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop      = drop;
    assign o_overflow_count = 16'h0000;
`endif

endmodule

// File: doc/adc_stream_fifo.md
ADC_STREAM_FIFO -- requirements
Module: adc_stream_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter EMPTY_DATA, default 32'hDEADBEEF, value presented on o_rx_data when the FIFO is empty.
REQ-003 i_clk  in  1  single clock; all logic on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_clear  in  1  synchronous flush strobe.
REQ-006 i_sample_valid  in  1  ADC sample strobe, one sample per asserted cycle.
REQ-007 i_sample  in  16  ADC sample.
REQ-008 o_rx_data  out  32  head-of-FIFO word (show-ahead), consumed by the register file's rx_data input.
REQ-009 i_rx_data_read_trigger  in  1  single-cycle pop strobe from the register file.
REQ-010 o_empty  out  1  FIFO holds no words.
REQ-011 o_full  out  1  FIFO holds 2**DEPTH_LOG2 words.
REQ-012 o_level  out  DEPTH_LOG2+1  current word count.
REQ-013 o_overflow_count  out  16  count of dropped words.

Function
REQ-014 The packer SHALL hold one pending sample: first valid sample is stored as low half; the next valid sample forms word {sample, low} and SHALL be pushed on that same edge.
REQ-015 The packer SHALL track phase with a 1-bit state: LOW (awaiting first half) -> HIGH on valid sample; HIGH -> LOW on valid sample (push attempt).
REQ-016 A push SHALL be accepted if not full, or if full and a pop occurs on the same edge.
REQ-017 A rejected push SHALL drop the whole word, leave FIFO contents unchanged, return the packer to LOW, and increment o_overflow_count, saturating at 16'hFFFF.
REQ-018 o_rx_data SHALL equal the oldest stored word while not empty, and EMPTY_DATA while empty, combinationally from the storage and read pointer (zero-latency show-ahead).
REQ-019 A trigger while not empty SHALL pop one word; o_rx_data SHALL show the next word (or EMPTY_DATA) the cycle after the pop edge.
REQ-020 A trigger while empty SHALL be ignored; pointers and level SHALL not change.
REQ-021 Simultaneous accepted push and pop SHALL leave o_level unchanged; with level 0 a same-cycle push SHALL not be popped by a concurrent trigger.
REQ-022 Read/write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth; o_level SHALL be the separate DEPTH_LOG2+1-bit count.
REQ-023 o_empty = (o_level == 0); o_full = (o_level == 2**DEPTH_LOG2); both registered-derived, no combinational path from inputs.
REQ-024 i_clear SHALL empty the FIFO, return the packer to LOW, discard the pending half, and zero o_overflow_count; it SHALL override push and pop in the same cycle.

Reset
REQ-025 Asserting i_rst SHALL immediately set pointers and o_level to 0, packer to LOW, pending half to 0, o_overflow_count to 0; hence o_empty=1, o_full=0, o_rx_data=EMPTY_DATA.
REQ-026 Reset asserted mid-packing or mid-pop SHALL discard all state; the first sample after release SHALL be a low half.
REQ-027 Storage contents need not be reset.

Configuration
REQ-028 Macro ADC_STREAM_FIFO_OVF_COUNT_EN defined: overflow counter per REQ-017/REQ-024 is built.
REQ-029 Macro ADC_STREAM_FIFO_OVF_COUNT_EN undefined: no counter logic, o_overflow_count tied to 16'h0000; drop behaviour otherwise identical.

Verification
REQ-030 Reset, then samples 16'h0001, 16'h0002 -> o_rx_data=32'h00020001, o_level=1, o_empty=0; one trigger -> o_rx_data=32'hDEADBEEF, o_empty=1.
REQ-031 Trigger with FIFO empty -> o_level stays 0, o_rx_data stays 32'hDEADBEEF.
REQ-032 Push 17 words (samples 0..33), DEPTH_LOG2=4 -> o_full=1, o_level=16, o_overflow_count=1, head=32'h00010000; 16 triggers drain words in order, last=32'h001F001E.
REQ-033 FIFO full, final sample of a word arrives in same cycle as trigger -> push accepted, o_level stays 16, o_overflow_count unchanged.
REQ-034 One sample 16'hAAAA then i_clear, then samples 16'h0005, 16'h0006 -> head=32'h00060005, o_level=1, o_overflow_count=0.
REQ-035 i_rst pulsed with 3 words stored and packer HIGH -> o_level=0, o_rx_data=32'hDEADBEEF immediately (before next clock edge); build without ADC_STREAM_FIFO_OVF_COUNT_EN repeats REQ-032 with o_overflow_count=0.
